// File: rtl/rv_dmem_resp_if.sv
// ---------------------------------------------------------------------------
// rv_dmem_resp_if
// Request/response bundle between the core's data-memory port and the
// data-memory responder.
//   req    : access request, sampled only while ready=1
//   we     : 1=write, 0=read (qualified by req)
//   addr   : byte address
//   wdata  : write data
//   ready  : responder can accept a request this cycle
//   rvalid : one-cycle response strobe
//   rdata  : read data / write echo, valid with rvalid, held afterwards
//   err    : access error flag, valid with rvalid
// master = core side, slave = responder side.
// ---------------------------------------------------------------------------
interface rv_dmem_resp_if #(
    parameter int DPWIDTH = 32
);
    logic               req;
    logic               we;
    logic [DPWIDTH-1:0] addr;
    logic [DPWIDTH-1:0] wdata;
    logic               ready;
    logic               rvalid;
    logic [DPWIDTH-1:0] rdata;
    logic               err;

    modport master (
        output req, we, addr, wdata,
        input  ready, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, rvalid, rdata, err
    );
endinterface

// File: rtl/rv_dmem_resp.sv
// ---------------------------------------------------------------------------
// rv_dmem_resp
// Data-memory responder for the multicycle RISC-V core. Accepts one access
// at a time over a req/ready/rvalid handshake, waits LATENCY cycles, then
// produces a single-cycle response. Accesses are word aligned and range
// checked against BASE_ADDR/DEPTH; completed accesses are counted in
// saturating statistics counters.
// Ports:
//   clk         : clock, all state on rising edge
//   rst         : asynchronous active-low reset
//   bus         : slave side of rv_dmem_resp_if (req/we/addr/wdata in,
//                 ready/rvalid/rdata/err out)
//   stat_reads  : completed good reads  (saturating)
//   stat_writes : completed good writes (saturating)
//   stat_errs   : errored accesses      (saturating)
// The storage array is not reset.
// ---------------------------------------------------------------------------
module rv_dmem_resp #(
    parameter int          DPWIDTH   = 32,
    parameter int          DEPTH     = 256,
    parameter int          LATENCY   = 2,
    parameter int unsigned BASE_ADDR = 0,
    parameter int          STATW     = 16
) (
    input  logic             clk,
    input  logic             rst,
    rv_dmem_resp_if.slave    bus,
    output logic [STATW-1:0] stat_reads,
    output logic [STATW-1:0] stat_writes,
    output logic [STATW-1:0] stat_errs
);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("rv_dmem_resp: LATENCY=%0d outside legal range 1..15", LATENCY);
        end
        if ((BASE_ADDR % 4) != 0) begin : g_bad_base
            $error("rv_dmem_resp: BASE_ADDR=0x%0h is not word aligned", BASE_ADDR);
        end
    endgenerate

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Wait counter preload: BUSY lasts LATENCY-1 cycles, exiting when cnt==0.
    localparam logic [3:0]         CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic [DPWIDTH-1:0] BASE     = DPWIDTH'(BASE_ADDR);
    localparam logic [DPWIDTH-1:0] DEPTH_W  = DPWIDTH'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // With a single-cycle latency the accepting edge is also the edge that
    // enters RESP, so there is no BUSY phase at all.
    localparam state_t ACC_STATE = (LATENCY == 1) ? RESP : BUSY;

    function automatic logic [STATW-1:0] sat_inc(input logic [STATW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         cnt;
    logic               accept;
    logic               enter_resp;

    logic               we_p0;
    logic [DPWIDTH-1:0] addr_p0;
    logic [DPWIDTH-1:0] wdata_p0;

    logic               t_we;
    logic [DPWIDTH-1:0] t_addr;
    logic [DPWIDTH-1:0] t_wdata;
    logic [DPWIDTH-1:0] t_off;
    logic [DPWIDTH-1:0] t_idx_full;
    logic [AW-1:0]      t_idx;
    logic               t_err;

    logic [DPWIDTH-1:0] rdata_q;
    logic               err_q;

    logic [DPWIDTH-1:0] mem [DEPTH];

    assign bus.ready  = (state != BUSY);
    assign bus.rvalid = (state == RESP);
    assign bus.rdata  = rdata_q;
    assign bus.err    = err_q;

    assign accept     = bus.req & bus.ready;
    assign enter_resp = (state_nxt == RESP);

    // The transaction that completes on the RESP-entering edge: live inputs
    // for single-cycle latency, otherwise the request captured at accept.
    assign t_we    = (LATENCY == 1) ? bus.we    : we_p0;
    assign t_addr  = (LATENCY == 1) ? bus.addr  : addr_p0;
    assign t_wdata = (LATENCY == 1) ? bus.wdata : wdata_p0;

    // Range check runs on the full-width offset before any bits are dropped,
    // so addresses past the array never alias onto low words.
    assign t_off      = t_addr - BASE;
    assign t_idx_full = t_off >> 2;
    assign t_idx      = t_idx_full[AW-1:0];
    assign t_err      = (t_addr[1:0] != 2'b00) || (t_addr < BASE) || (t_idx_full >= DEPTH_W);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = ACC_STATE;
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = accept ? ACC_STATE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---- p0: request capture at the accepting edge ----
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0    <= bus.we;
            addr_p0  <= bus.addr;
            wdata_p0 <= bus.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 4'd0;
        end else if (accept) begin
            cnt <= CNT_LOAD;
        end else if (state == BUSY) begin
            cnt <= cnt - 4'd1;
        end
    end

    // ---- response: array access, response data and statistics ----
    always_ff @(posedge clk) begin
        if (enter_resp && t_we && !t_err) begin
            mem[t_idx] <= t_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q     <= '0;
            err_q       <= 1'b0;
            stat_reads  <= '0;
            stat_writes <= '0;
            stat_errs   <= '0;
        end else if (enter_resp) begin
            err_q <= t_err;
            if (t_err) begin
                rdata_q   <= '0;
                stat_errs <= sat_inc(stat_errs);
            end else if (t_we) begin
                rdata_q     <= t_wdata;
                stat_writes <= sat_inc(stat_writes);
            end else begin
                rdata_q    <= mem[t_idx];
                stat_reads <= sat_inc(stat_reads);
            end
        end
    end

endmodule

// File: doc/rv_dmem_resp.md
Name: rv_dmem_resp

Overview:
- Data-memory responder for the multicycle RISC-V core: the memory-side end of the core's dmem address/data interface.
- Adds a req/ready/rvalid handshake, a configurable wait-state count, word-aligned range checking and saturating access statistics.
- Sits between the core's control/datapath and a word-wide storage array; acts as a bench memory model and as the base of the on-chip data RAM.

Parameters:
DPWIDTH, 32, data and address width in bits
DEPTH, 256, number of DPWIDTH-bit words stored
LATENCY, 2, cycles from accepting edge to rvalid; legal range 1..15
BASE_ADDR, 0, byte address of word 0; must be word aligned
STATW, 16, width of statistics counters

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
req  input  1  access request, sampled only when ready=1
we  input  1  1=write, 0=read; qualified by req
addr  input  DPWIDTH  byte address
wdata  input  DPWIDTH  write data
ready  output  1  responder can accept a request this cycle
rvalid  output  1  one-cycle response strobe
rdata  output  DPWIDTH  read data, valid when rvalid=1, held afterwards
err  output  1  access error flag, valid when rvalid=1
stat_reads  output  STATW  count of completed good reads
stat_writes  output  STATW  count of completed good writes
stat_errs  output  STATW  count of errored accesses

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; ready=1, rvalid=0, rdata=0, err=0, all stat counters=0; storage array not reset; any pending access is dropped, pending write never committed.
- FSM states:
  - IDLE: ready=1.
  - BUSY: ready=0; wait counter running.
  - RESP: ready=1, rvalid=1, lasts exactly one cycle.
- Accept: edge with req=1 and ready=1 captures we, addr, wdata. Next state is RESP if LATENCY=1, else BUSY with the counter loaded so RESP occurs LATENCY cycles after the accepting edge.
- Request timing:
  - req while ready=0 is ignored: no queuing, no error. The initiator holds req until accepted.
  - Back-to-back: req=1 during RESP is accepted at the RESP-ending edge, so a new transaction starts with zero idle cycles.
  - RESP without a new accept returns to IDLE.
- Address check: index = (addr - BASE_ADDR) >> 2.
  - Error if addr[1:0] != 0, addr < BASE_ADDR, or index >= DEPTH.
  - Captured error: no array access; rdata=0 and err=1 in RESP; stat_errs increments.
- Write: array word updated at the edge entering RESP. In RESP, rdata = written value (echo) and err=0; stat_writes increments.
- Read: rdata = array word at the edge entering RESP, err=0; stat_reads increments.
- rdata and err hold their last values outside RESP until the next response.
- Read-after-write: a read accepted in the RESP cycle of a write to the same word returns the new data.
- Stat counters increment at the edge entering RESP and saturate at all-ones (no wrap).
- Unused DEPTH/address bits ignored only after the range check passes.
- LATENCY outside 1..15 is a configuration error: flag it with an elaboration-time assertion.

Test Plan:
- Reset then LATENCY=2, BASE_ADDR=0: write 0xDEADBEEF to addr 0x10, then read 0x10 -> rvalid exactly 2 cycles after each accept, read rdata=0xDEADBEEF, err=0, stat_writes=1, stat_reads=1.
- Back-to-back: write 0x11111111 @0x0 with req held high into its RESP, read @0x0 accepted in that RESP cycle -> read returns 0x11111111, no idle cycle between transactions.
- Errors with BASE_ADDR=0x1000, DEPTH=256:
  - read 0x1002 (misaligned) -> rvalid, err=1, rdata=0.
  - write 0x1400 (index 256) -> err=1, no array change; read 0x13FC afterwards returns its prior value.
  - read 0x0FFC -> err=1.
  - stat_errs=3.
- req pulsed while ready=0 (during BUSY) with a different addr -> ignored; the response reflects only the first request; stat counts increment once.
- Reset mid-operation: accept write 0xCAFEF00D @0x20, drive rst=0 one cycle later -> rvalid never asserts, outputs return to reset values immediately; a later read of 0x20 does not return 0xCAFEF00D.
- Saturation with STATW=4: 20 good reads -> stat_reads=15 and holds; LATENCY=1 run -> rvalid in the cycle right after every accept.
